// File: rtl/dec_ser_pkg.sv
// Shared types and width helpers for the multi-channel decimator serializer.
// Keeps the state encoding and frame geometry in one place for top and bench.
package dec_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_bits(input int n, input int dw, input int tag_en);
        return ((tag_en != 0) ? ch_bits(n) : 0) + dw;
    endfunction

endpackage

// File: rtl/dec_ser_fifo.sv
// Shared word FIFO; read data is presented combinationally so a pop
// consumes the head entry in the same cycle it is requested.
module dec_ser_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wp[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                wp <= wp + 1'b1;
            end
            if (pop && !empty) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decimator_ser_mc.sv
// Multi-channel decimator serializer: per-channel hold regs, priority loader,
// shared FIFO and a framed serial output with optional channel tag.
module decimator_ser_mc
    import dec_ser_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    parameter int TAG_EN     = 1,
    parameter int GAP        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        valid_i,
    input  logic [N_CH*DATA_W-1:0] data_i,
    output logic                   data_o,
    output logic                   frame_sync,
    output logic                   busy,
    output logic                   ovf_o,
    input  logic                   ovf_clr_i
);

    localparam int CH_W     = ch_bits(N_CH);
    localparam int FRAME_W  = frame_bits(N_CH, DATA_W, TAG_EN);
    localparam int ENT_W    = CH_W + DATA_W;
    localparam int BC_W     = $clog2(FRAME_W);
    localparam int GC_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    logic [DATA_W-1:0]  hold [N_CH];
    logic [N_CH-1:0]    hold_vld;
    logic [N_CH-1:0]    drained;
    logic [CH_W-1:0]    sel;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               ovf_set;
    logic [ENT_W-1:0]   wr_ent;
    logic [ENT_W-1:0]   rd_ent;
    logic [CH_W-1:0]    rd_tag;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  data_rev;
    logic [DATA_W-1:0]  data_ord;
    logic [FRAME_W-1:0] frame_word;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [BC_W-1:0]    bit_cnt;
    logic [GC_W-1:0]    gap_cnt;
    logic               last_bit;
    logic               gap_done;
    logic               start;

    // Lowest-numbered pending channel wins the single push slot.
    always_comb begin
        sel = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (hold_vld[c]) begin
                sel = CH_W'(c);
            end
        end
    end

    assign push   = (|hold_vld) && !full;
    assign wr_ent = {sel, hold[sel]};

    always_comb begin
        drained = '0;
        ovf_set = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            drained[c] = push && (sel == CH_W'(c));
            if (valid_i[c] && hold_vld[c] && !drained[c]) begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld <= '0;
            for (int c = 0; c < N_CH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (valid_i[c] && (!hold_vld[c] || drained[c])) begin
                    hold[c]     <= data_i[c*DATA_W +: DATA_W];
                    hold_vld[c] <= 1'b1;
                end else if (drained[c]) begin
                    hold_vld[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (ovf_set) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    dec_ser_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_ent),
        .rdata (rd_ent),
        .full  (full),
        .empty (empty)
    );

    assign {rd_tag, rd_data} = rd_ent;

    always_comb begin
        data_rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_rev[i] = rd_data[DATA_W-1-i];
        end
    end

    assign data_ord = (MSB_FIRST != 0) ? rd_data : data_rev;

    // The shifter always emits its MSB, so LSB-first data is pre-reversed.
    if (TAG_EN != 0) begin : g_tag
        assign frame_word = {rd_tag, data_ord};
    end else begin : g_notag
        logic unused_tag;
        assign unused_tag = ^rd_tag;
        assign frame_word = data_ord;
    end

    assign last_bit = (bit_cnt == BC_W'(FRAME_W - 1));
    assign gap_done = (gap_cnt == GC_W'(GAP_LAST));
    assign start    = !empty && ((state == S_IDLE) ||
                                 (state == S_SHIFT && last_bit && GAP == 0) ||
                                 (state == S_GAP && gap_done));
    assign pop      = start;
    assign busy     = (|hold_vld) || !empty || (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            data_o     <= 1'b0;
            frame_sync <= 1'b0;
        end else if (start) begin
            state      <= S_SHIFT;
            shreg      <= frame_word << 1;
            data_o     <= frame_word[FRAME_W-1];
            frame_sync <= 1'b1;
            bit_cnt    <= '0;
        end else begin
            unique case (state)
                S_SHIFT: begin
                    if (last_bit) begin
                        data_o     <= 1'b0;
                        frame_sync <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        data_o  <= shreg[FRAME_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    data_o     <= 1'b0;
                    frame_sync <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimator_ser_mc.sv
// Directed bench: default instance (tagged, MSB first, GAP=1) plus an
// untagged LSB-first back-to-back instance.
module tb_decimator_ser_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ovf_clr = 1'b0;
    logic [1:0]  valid1 = '0;
    logic [43:0] data1 = '0;
    logic [1:0]  valid2 = '0;
    logic [43:0] data2 = '0;
    logic        d1, fs1, busy1, ovf1;
    logic        d2, fs2, busy2, ovf2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decimator_ser_mc dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid1),
        .data_i     (data1),
        .data_o     (d1),
        .frame_sync (fs1),
        .busy       (busy1),
        .ovf_o      (ovf1),
        .ovf_clr_i  (ovf_clr)
    );

    decimator_ser_mc #(
        .N_CH       (2),
        .DATA_W     (22),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (0),
        .TAG_EN     (0),
        .GAP        (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid2),
        .data_i     (data2),
        .data_o     (d2),
        .frame_sync (fs2),
        .busy       (busy2),
        .ovf_o      (ovf2),
        .ovf_clr_i  (ovf_clr)
    );

    task automatic strobe1(input logic [1:0] v, input logic [21:0] w0, input logic [21:0] w1);
        valid1 = v;
        data1  = {w1, w0};
        @(negedge clk);
        valid1 = '0;
    endtask

    task automatic wait_frame(input int which, input int maxw,
                              output logic [127:0] bits, output int len);
        int w;
        bits = '0;
        len  = 0;
        w    = 0;
        while (((which == 0) ? fs1 : fs2) == 1'b0 && w < maxw) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (((which == 0) ? fs1 : fs2) !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_timeout inst=%0d: frame_sync=0 after %0d cycles, required 1", which, w);
        end
        while (((which == 0) ? fs1 : fs2) === 1'b1 && len < 128) begin
            bits = {bits[126:0], ((which == 0) ? d1 : d2)};
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({d1, fs1, busy1, ovf1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000", {d1, fs1, busy1, ovf1});
        end
        n_chk++;
        if ({d2, fs2, busy2, ovf2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs2: got %b, required 0000", {d2, fs2, busy2, ovf2});
        end
    endtask

    task automatic test_single_frame();
        logic [127:0] b;
        int len;
        strobe1(2'b01, 22'h2AAAAA, 22'h0);
        n_chk++;
        if (fs1 !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_e1: frame_sync=%b, required 0", fs1);
        end
        @(negedge clk);
        n_chk++;
        if (fs1 !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_e2: frame_sync=%b, required 0", fs1);
        end
        @(negedge clk);
        n_chk++;
        if (fs1 !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_e3: frame_sync=%b, required 1", fs1);
        end
        wait_frame(0, 0, b, len);
        n_chk++;
        if (len != 23 || b[22:0] !== {1'b0, 22'h2AAAAA}) begin
            n_fail++;
            $display("FAIL single_frame: len=%0d bits=%h, required len=23 bits=%h",
                     len, b[22:0], {1'b0, 22'h2AAAAA});
        end
        n_chk++;
        if (d1 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_data: data_o=%b, required 0", d1);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b ovf=%b, required 0 0", busy1, ovf1);
        end
    endtask

    task automatic test_two_channels();
        logic [127:0] b;
        int len;
        strobe1(2'b11, 22'h000001, 22'h3FFFFF);
        wait_frame(0, 10, b, len);
        n_chk++;
        if (len != 23 || b[22:0] !== {1'b0, 22'h000001}) begin
            n_fail++;
            $display("FAIL ch0_first: len=%0d bits=%h, required len=23 bits=%h",
                     len, b[22:0], {1'b0, 22'h000001});
        end
        @(negedge clk);
        n_chk++;
        if (fs1 !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_one_cycle: frame_sync=%b after 1 idle cycle, required 1", fs1);
        end
        wait_frame(0, 0, b, len);
        n_chk++;
        if (len != 23 || b[22:0] !== {1'b1, 22'h3FFFFF}) begin
            n_fail++;
            $display("FAIL ch1_second: len=%0d bits=%h, required len=23 bits=%h",
                     len, b[22:0], {1'b1, 22'h3FFFFF});
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (ovf1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL two_ch_end: ovf=%b busy=%b, required 0 0", ovf1, busy1);
        end
    endtask

    task automatic test_lsb_notag();
        logic [127:0] b;
        int len;
        valid2 = 2'b01;
        data2  = {22'h0, 22'h000001};
        @(negedge clk);
        valid2 = '0;
        wait_frame(1, 10, b, len);
        n_chk++;
        if (len != 22 || b[21:0] !== 22'h200000) begin
            n_fail++;
            $display("FAIL lsb_notag: len=%0d bits=%h, required len=22 bits=200000", len, b[21:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b;
        logic [65:0]  exp;
        int len;
        exp    = {22'h300000, 22'h03C000, 22'h155555};
        valid2 = 2'b11;
        data2  = {22'h2AAAAA, 22'h000003};
        @(negedge clk);
        valid2 = 2'b01;
        data2  = {22'h0, 22'h0000F0};
        @(negedge clk);
        valid2 = '0;
        wait_frame(1, 10, b, len);
        n_chk++;
        if (len != 66 || b[65:0] !== exp) begin
            n_fail++;
            $display("FAIL back_to_back: len=%0d bits=%h, required len=66 bits=%h", len, b[65:0], exp);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy2 !== 1'b0 || ovf2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b ovf=%b, required 0 0", busy2, ovf2);
        end
    endtask

    task automatic test_overflow();
        int extra;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    valid1 = 2'b01;
                    data1  = {22'h0, 22'h3C0000 + 22'(i)};
                    @(negedge clk);
                    if (i == 5) begin
                        n_chk++;
                        if (ovf1 !== 1'b0) begin
                            n_fail++;
                            $display("FAIL ovf_early: ovf=%b at strobe 5, required 0", ovf1);
                        end
                    end
                    if (i == 6) begin
                        n_chk++;
                        if (ovf1 !== 1'b1) begin
                            n_fail++;
                            $display("FAIL ovf_set: ovf=%b at strobe 6, required 1", ovf1);
                        end
                    end
                end
                valid1 = '0;
                repeat (5) @(negedge clk);
                n_chk++;
                if (ovf1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_sticky: ovf=%b, required 1", ovf1);
                end
            end
            begin
                logic [127:0] b;
                int len;
                for (int k = 0; k < 6; k++) begin
                    wait_frame(0, 60, b, len);
                    n_chk++;
                    if (len != 23 || b[22:0] !== {1'b0, 22'h3C0000 + 22'(k)}) begin
                        n_fail++;
                        $display("FAIL ovf_frame%0d: len=%0d bits=%h, required len=23 bits=%h",
                                 k, len, b[22:0], {1'b0, 22'h3C0000 + 22'(k)});
                    end
                end
            end
        join
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fs1 === 1'b1) extra++;
        end
        n_chk++;
        if (extra != 0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_no_extra: extra_cycles=%0d busy=%b, required 0 0", extra, busy1);
        end
        n_chk++;
        if (ovf1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: ovf=%b before clear, required 1", ovf1);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_chk++;
        if (ovf1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int seen;
        strobe1(2'b11, 22'h155555, 22'h0AAAAA);
        w = 0;
        while (fs1 !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (fs1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_frame_start: frame_sync=%b, required 1", fs1);
        end
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({fs1, d1, busy1} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_frame: fs/data/busy=%b, required 000", {fs1, d1, busy1});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (fs1 === 1'b1 || busy1 === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_resume: active cycles=%0d, required 0", seen);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single_frame();
        test_two_channels();
        test_lsb_notag();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
